// File: rtl/arith_fsm_if.sv
// arith_fsm_if: go/busy/done handshake and operand/result bundle for arith_fsm
interface arith_fsm_if #(parameter int WIDTH = 6);
    logic             go;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             err;
    modport master (output go, op, a, b, input busy, done, result, result_hi, carry, err);
    modport slave  (input go, op, a, b, output busy, done, result, result_hi, carry, err);
endinterface

// File: rtl/arith_fsm.sv
// arith_fsm: multi-cycle ADD/SUB/shift-add MUL unit; ARITH_FSM_DIV_EN adds restoring DIV on op=3
module arith_fsm #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 6
) (
    input logic        CLK,
    input logic        reset_n,
    arith_fsm_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
    logic               carry_q, carry_d, err_q, err_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step;
    logic [WIDTH:0]     add_sum, mul_sum;
    logic               iter, last;

    assign add_sum = {1'b0, a_q} + {1'b0, b_q};
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    assign last    = cnt_q == CNT_W'(WIDTH - 1);

`ifdef ARITH_FSM_DIV_EN
    logic [WIDTH:0]   div_t;
    logic [WIDTH-1:0] div_rem;
    logic             div_ge;
    // Restoring step: shift the next dividend bit into the partial remainder, subtract b if it fits
    assign div_t   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = div_t >= {1'b0, b_q};
    assign div_rem = div_t[WIDTH-1:0] - b_q;
    assign iter    = op_q[1];
    assign step    = op_q[0] ? {(div_ge ? div_rem : div_t[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge}
                             : {mul_sum, acc_q[WIDTH-1:1]};
`else
    assign iter    = op_q == 2'd2;
    assign step    = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.carry     = carry_q;
    assign bus.err       = err_q;

    // State, latched operands, accumulator and held results; reset abandons any operation
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    // Next state: accept in IDLE, iterate or finish in EXEC, results load only on DONE entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.go) begin
                state_d = EXEC;
                op_d    = bus.op;
                a_d     = bus.a;
                b_d     = bus.b;
                cnt_d   = '0;
                acc_d   = {{WIDTH{1'b0}}, (bus.op == 2'd3 ? bus.a : bus.b)};
            end
            EXEC: if (iter) begin
                acc_d = step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d      = DONE;
                    {hi_d, res_d} = step;
                    carry_d      = 1'b0;
                    err_d        = op_q[0] && b_q == '0;
                end
            end else begin
                state_d = DONE;
                hi_d    = '0;
                res_d   = op_q == 2'd0 ? add_sum[WIDTH-1:0] : op_q == 2'd1 ? a_q - b_q : '0;
                carry_d = op_q == 2'd0 ? add_sum[WIDTH] : op_q == 2'd1 && a_q < b_q;
                err_d   = op_q[1];
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_arith_fsm.sv
// tb_arith_fsm: directed checks of arith_fsm at WIDTH=6 (DIV cases when ARITH_FSM_DIV_EN is defined)
module tb_arith_fsm;
    localparam int W = 6;

    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    arith_fsm_if #(.WIDTH(W)) bus ();
    arith_fsm #(.WIDTH(W), .CNT_W(6)) dut (.CLK(CLK), .reset_n(reset_n), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp_lat);
        int lat;
        @(negedge CLK);
        bus.go = 1'b1;
        bus.op = o;
        bus.a  = x;
        bus.b  = y;
        @(posedge CLK);
        #1 bus.go = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge CLK);
            #1 lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        @(posedge CLK);
        #1 check({tag, " idle after done"}, {bus.busy, bus.done}, 0);
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo,
                             input logic c, input logic e);
        check({tag, " result"}, bus.result, lo);
        check({tag, " result_hi"}, bus.result_hi, hi);
        check({tag, " carry"}, bus.carry, c);
        check({tag, " err"}, bus.err, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   dn, gap, n;
        int   acc_edge[$];
        logic pb, pd;
        bus.go = 1'b0;
        bus.op = 2'd0;
        bus.a  = '0;
        bus.b  = '0;
        repeat (2) @(posedge CLK);
        #1 check("reset busy/done", {bus.busy, bus.done}, 0);
        check_out("reset", 0, 0, 0, 0);
        @(negedge CLK) reset_n = 1'b1;

        run_op("add 2+5", 2'd0, 2, 5, 1);
        check_out("add 2+5", 0, 7, 0, 0);
        run_op("add 60+10", 2'd0, 60, 10, 1);
        check_out("add 60+10", 0, 6, 1, 0);
        run_op("sub 5-7", 2'd1, 5, 7, 1);
        check_out("sub 5-7", 0, 62, 1, 0);
        run_op("mul 63*63", 2'd2, 63, 63, 6);
        check_out("mul 63*63", 62, 1, 0, 0);
        run_op("sub 9-4", 2'd1, 9, 4, 1);
        check_out("sub 9-4", 0, 5, 0, 0);
        run_op("mul 7*9", 2'd2, 7, 9, 6);
        check_out("mul 7*9", 0, 63, 0, 0);

        // go held for 20 edges: accepts at edges 1, 9, 17; operands change after edge 2
        dn = 0;
        gap = 0;
        pb = 1'b0;
        pd = 1'b0;
        @(negedge CLK);
        bus.go = 1'b1;
        bus.op = 2'd2;
        bus.a  = 3;
        bus.b  = 5;
        for (int i = 1; i <= 32; i++) begin
            @(posedge CLK);
            #1;
            if (i == 2) begin
                bus.a = 10;
                bus.b = 11;
            end
            if (i == 20) bus.go = 1'b0;
            if (bus.busy && !pb) acc_edge.push_back(i);
            if (bus.done) begin
                dn++;
                check("held-go product", {bus.result_hi, bus.result}, dn == 1 ? 15 : 110);
            end
            if (pd && (bus.busy || bus.done)) gap++;
            pb = bus.busy;
            pd = bus.done;
        end
        check("held-go done count", dn, 3);
        check("held-go accept count", acc_edge.size(), 3);
        for (int j = 0; j < 3; j++)
            check("held-go accept edge", j < acc_edge.size() ? acc_edge[j] : -1, 1 + 8 * j);
        check("held-go idle gap", gap, 0);

        // asynchronous reset after three MUL iterations
        @(negedge CLK);
        bus.go = 1'b1;
        bus.op = 2'd2;
        bus.a  = 63;
        bus.b  = 63;
        @(posedge CLK);
        #1 bus.go = 1'b0;
        repeat (3) @(posedge CLK);
        #3 reset_n = 1'b0;
        #1 check("mid-op reset busy/done", {bus.busy, bus.done}, 0);
        check_out("mid-op reset", 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) reset_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge CLK);
            #1 if (bus.done) n++;
        end
        check("no done after reset", n, 0);
        run_op("add 20+30", 2'd0, 20, 30, 1);
        check_out("add 20+30", 0, 50, 0, 0);

`ifdef ARITH_FSM_DIV_EN
        run_op("div 45/7", 2'd3, 45, 7, 6);
        check_out("div 45/7", 3, 6, 0, 0);
        run_op("div 45/0", 2'd3, 45, 0, 6);
        check_out("div 45/0", 45, 63, 0, 1);
`else
        run_op("illegal op3", 2'd3, 45, 7, 1);
        check_out("illegal op3", 0, 0, 0, 1);
`endif
        run_op("add 1+1", 2'd0, 1, 1, 1);
        check_out("add 1+1", 0, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
